// File: rtl/acc_burst_arbiter.sv
// Round-robin arbiter that lends one shared byte accumulator to NUM_REQ burst requesters
// and returns each burst's total tagged with requester id, beat count and truncation flag.
module acc_burst_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = 2,
    parameter int MAX_BEATS = 257
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 acc_clr,
    output logic                 acc_en,
    output logic [7:0]           acc_data,
    input  logic [15:0]          acc_sum,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [15:0]          res_sum,
    output logic [ID_W-1:0]      res_id,
    output logic [8:0]           res_cnt,
    output logic                 res_trunc,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_SETTLE,
        S_RESULT
    } state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant;
    logic [8:0]      beat_cnt;

    logic [ID_W-1:0] pick;
    logic            pick_vld;
    logic            g_valid;
    logic            g_last;
    logic [7:0]      g_data;
    logic            accept;
    logic [8:0]      beat_cnt_nxt;
    logic            at_max;
    int              idx_i;

    // Lowest offset from rr_ptr wins, so the scan runs from the far end downward.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx_i    = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx_i = (int'(rr_ptr) + k) % NUM_REQ;
            if (req_valid[idx_i[ID_W-1:0]]) begin
                pick     = idx_i[ID_W-1:0];
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        g_valid   = 1'b0;
        g_last    = 1'b0;
        g_data    = '0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == ID_W'(i)) begin
                g_valid      = req_valid[i];
                g_last       = req_last[i];
                g_data       = req_data[i*8 +: 8];
                req_ready[i] = (state == S_STREAM);
            end
        end
    end

    assign accept       = (state == S_STREAM) && g_valid;
    assign beat_cnt_nxt = beat_cnt + 9'd1;
    assign at_max       = (beat_cnt_nxt == 9'(MAX_BEATS));

    assign acc_en    = accept;
    assign acc_data  = accept ? g_data : 8'd0;
    assign acc_clr   = (state == S_CLEAR);
    assign res_valid = (state == S_RESULT);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clock) begin
        if (rst) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            grant     <= '0;
            beat_cnt  <= '0;
            res_sum   <= '0;
            res_id    <= '0;
            res_cnt   <= '0;
            res_trunc <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        grant  <= pick;
                        rr_ptr <= (int'(pick) == NUM_REQ - 1) ? '0 : pick + 1'b1;
                        state  <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    beat_cnt <= '0;
                    state    <= S_STREAM;
                end
                S_STREAM: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt_nxt;
                        if (g_last || at_max) begin
                            res_trunc <= at_max && !g_last;
                            state     <= S_SETTLE;
                        end
                    end
                end
                // Accumulator has absorbed the final beat by now.
                S_SETTLE: begin
                    res_sum <= acc_sum;
                    res_id  <= grant;
                    res_cnt <= beat_cnt;
                    state   <= S_RESULT;
                end
                S_RESULT: begin
                    if (res_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_burst_arbiter.sv
// Bench for acc_burst_arbiter: directed scenarios plus randomized bursts against a behavioural model.
module tb_acc_burst_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int ID_W      = 2;
    localparam int MAX_BEATS = 257;
    localparam int QD        = 1024;
    localparam int P_IDLE = 0, P_CLEAR = 1, P_STREAM = 2, P_SETTLE = 3, P_RESULT = 4;

    logic                 clock = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [NUM_REQ*8-1:0] req_data = '0;
    logic [NUM_REQ-1:0]   req_last = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 acc_clr, acc_en;
    logic [7:0]           acc_data;
    logic [15:0]          acc_sum = '0;
    logic                 res_valid;
    logic                 res_ready = 1'b0;
    logic [15:0]          res_sum;
    logic [ID_W-1:0]      res_id;
    logic [8:0]           res_cnt;
    logic                 res_trunc, busy;

    int total = 0;
    int bad = 0;

    acc_burst_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .MAX_BEATS(MAX_BEATS)) dut (
        .clock(clock), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .acc_clr(acc_clr), .acc_en(acc_en), .acc_data(acc_data), .acc_sum(acc_sum),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_id(res_id),
        .res_cnt(res_cnt), .res_trunc(res_trunc), .busy(busy)
    );

    always #5 clock = ~clock;

    // Accumulator the arbiter drives
    always @(posedge clock) begin
        if (acc_clr) acc_sum <= '0;
        else if (acc_en) acc_sum <= acc_sum + 16'(acc_data);
    end

    // Requester beat queues
    logic [7:0] qd[NUM_REQ][QD];
    logic       ql[NUM_REQ][QD];
    int         qg[NUM_REQ][QD];
    int         head[NUM_REQ] = '{default: 0};
    int         tail[NUM_REQ] = '{default: 0};
    int         gap_done[NUM_REQ] = '{default: 0};
    bit         took[NUM_REQ] = '{default: 0};
    bit         rnd_gaps = 0;
    int         rr_mode = 0;
    int         hold_cnt = 0;

    // Model state and observation log
    int  ph = P_IDLE, mg = 0, mrr = 0, mn = 0;
    bit  mtr = 0;
    int  mbeats[512];
    int  cyc = 0, clr_cnt = 0, en_cnt = 0, acc_cnt = 0, last_acc_cyc = 0, rise_cyc = 0;
    bit  prev_rv = 0;
    int  nlog = 0;
    int  log_id[64], log_sum[64], log_cnt[64], log_tr[64];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push(input int r, input int d, input bit l, input int g);
        qd[r][tail[r]] = 8'(d);
        ql[r][tail[r]] = l;
        qg[r][tail[r]] = g;
        tail[r]++;
    endtask

    task automatic clear_queues();
        for (int i = 0; i < NUM_REQ; i++) begin
            head[i] = 0;
            tail[i] = 0;
            gap_done[i] = 0;
        end
    endtask

    function automatic bit all_empty();
        bit e = 1;
        for (int i = 0; i < NUM_REQ; i++) if (head[i] != tail[i]) e = 0;
        return e;
    endfunction

    // Requester and result-consumer drivers
    initial forever begin
        bit v;
        @(posedge clock);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (took[i] && head[i] < tail[i]) begin
                head[i]++;
                gap_done[i] = 0;
            end
            v = 0;
            if (head[i] < tail[i]) begin
                if (gap_done[i] < qg[i][head[i]]) gap_done[i]++;
                else if (rnd_gaps && $urandom_range(0, 3) == 0) v = 0;
                else v = 1;
            end
            req_valid[i] = v;
            if (v) begin
                req_data[8*i +: 8] = qd[i][head[i]];
                req_last[i] = ql[i][head[i]];
            end else begin
                req_data[8*i +: 8] = 8'($urandom);
                req_last[i] = 1'($urandom);
            end
        end
        if (res_valid) hold_cnt++;
        case (rr_mode)
            0: res_ready = 1'b1;
            1: res_ready = 1'($urandom_range(0, 1));
            default: res_ready = (hold_cnt > 10);
        endcase
    end

    // Compare process: model predicts outputs each cycle, then steps on the coming edge
    initial forever begin
        bit acc;
        bit glast;
        int s;
        logic [NUM_REQ-1:0]   exp_ready;
        logic [NUM_REQ*8-1:0] sh;
        @(negedge clock);
        cyc++;
        acc = 0;
        glast = 0;
        for (int i = 0; i < NUM_REQ; i++) took[i] = 0;
        if (!rst) begin
            exp_ready = (ph == P_STREAM) ? (NUM_REQ'(1) << mg) : '0;
            acc = (ph == P_STREAM) && ((req_valid >> mg) & 1) != 0;
            glast = ((req_last >> mg) & 1) != 0;
            sh = req_data >> (8 * mg);
            check("busy", 32'(busy), 32'(ph != P_IDLE));
            check("acc_clr", 32'(acc_clr), 32'(ph == P_CLEAR));
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            check("acc_en", 32'(acc_en), 32'(acc));
            check("acc_data", 32'(acc_data), acc ? 32'(sh[7:0]) : 32'd0);
            check("res_valid", 32'(res_valid), 32'(ph == P_RESULT));
            if (ph == P_RESULT) begin
                s = 0;
                for (int j = 0; j < mn; j++) s += mbeats[j];
                check("res_sum", 32'(res_sum), 32'(s));
                check("res_id", 32'(res_id), 32'(mg));
                check("res_cnt", 32'(res_cnt), 32'(mn));
                check("res_trunc", 32'(res_trunc), 32'(mtr));
            end
            for (int i = 0; i < NUM_REQ; i++) took[i] = req_valid[i] & req_ready[i];
            if (acc_clr) clr_cnt++;
            if (acc_en) en_cnt++;
            if (acc) acc_cnt++;
            if (res_valid && !prev_rv) rise_cyc = cyc;
            if (acc && glast) last_acc_cyc = cyc;
        end
        prev_rv = res_valid;
        if (rst) begin
            ph = P_IDLE;
            mrr = 0;
            mn = 0;
        end else begin
            case (ph)
                P_IDLE: begin
                    for (int k = 0; k < NUM_REQ; k++) begin
                        int c;
                        c = (mrr + k) % NUM_REQ;
                        if (((req_valid >> c) & 1) != 0) begin
                            mg = c;
                            mrr = (c + 1) % NUM_REQ;
                            ph = P_CLEAR;
                            break;
                        end
                    end
                end
                P_CLEAR: begin
                    mn = 0;
                    ph = P_STREAM;
                end
                P_STREAM: begin
                    if (acc) begin
                        mbeats[mn] = int'(sh[7:0]);
                        mn++;
                        if (glast || mn == MAX_BEATS) begin
                            mtr = (mn == MAX_BEATS) && !glast;
                            ph = P_SETTLE;
                        end
                    end
                end
                P_SETTLE: ph = P_RESULT;
                default: begin
                    if (res_ready) begin
                        if (nlog < 64) begin
                            log_id[nlog]  = int'(res_id);
                            log_sum[nlog] = int'(res_sum);
                            log_cnt[nlog] = int'(res_cnt);
                            log_tr[nlog]  = int'(res_trunc);
                        end
                        nlog++;
                        ph = P_IDLE;
                    end
                end
            endcase
        end
    end

    task automatic do_reset();
        @(posedge clock);
        #2;
        rst = 1'b1;
        clear_queues();
        req_valid = '0;
        @(posedge clock);
        #2;
        rst = 1'b0;
        nlog = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clock);
        #1;
        check({tag, ".req_ready"}, 32'(req_ready), 32'd0);
        check({tag, ".acc_clr"}, 32'(acc_clr), 32'd0);
        check({tag, ".acc_en"}, 32'(acc_en), 32'd0);
        check({tag, ".acc_data"}, 32'(acc_data), 32'd0);
        check({tag, ".res_valid"}, 32'(res_valid), 32'd0);
        check({tag, ".res_sum"}, 32'(res_sum), 32'd0);
        check({tag, ".res_id"}, 32'(res_id), 32'd0);
        check({tag, ".res_cnt"}, 32'(res_cnt), 32'd0);
        check({tag, ".res_trunc"}, 32'(res_trunc), 32'd0);
        check({tag, ".busy"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit ok = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clock);
            #1;
            if (all_empty() && ph == P_IDLE && !busy && req_valid == '0) begin
                ok = 1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s.timeout: not idle after %0d cycles", tag, budget);
        end
    endtask

    task automatic check_log(input string tag, input int i, input int id, input int sum,
                             input int cnt, input int tr);
        check({tag, ".id"}, 32'(log_id[i]), 32'(id));
        check({tag, ".sum"}, 32'(log_sum[i]), 32'(sum));
        check({tag, ".cnt"}, 32'(log_cnt[i]), 32'(cnt));
        check({tag, ".trunc"}, 32'(log_tr[i]), 32'(tr));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_tot[NUM_REQ];
        int got_tot[NUM_REQ];
        int nb;

        clear_queues();
        repeat (3) @(posedge clock);
        #2;
        rst = 1'b0;
        check_reset_outputs("reset");

        // req0: 10,20,30
        rr_mode = 0;
        clr_cnt = 0;
        nlog = 0;
        push(0, 10, 0, 0); push(0, 20, 0, 0); push(0, 30, 1, 0);
        wait_done("simple", 200);
        check("simple.nres", 32'(nlog), 32'd1);
        check_log("simple", 0, 0, 60, 3, 0);
        check("simple.clr_pulses", 32'(clr_cnt), 32'd1);
        check("simple.latency", 32'(rise_cyc - last_acc_cyc), 32'd2);

        // all four one beat of 1
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) push(i, 1, 1, 0);
        wait_done("all4", 200);
        check("all4.nres", 32'(nlog), 32'd4);
        for (int i = 0; i < NUM_REQ; i++) begin
            check("all4.id", 32'(log_id[i]), 32'(i));
            check("all4.sum", 32'(log_sum[i]), 32'd1);
        end

        // truncation at MAX_BEATS
        do_reset();
        for (int i = 0; i < MAX_BEATS; i++) push(2, 255, 0, 0);
        push(2, 5, 1, 0);
        wait_done("trunc", 2000);
        check("trunc.nres", 32'(nlog), 32'd2);
        check_log("trunc0", 0, 2, 65535, 257, 1);
        check_log("trunc1", 1, 2, 5, 1, 0);

        // result back-pressure with another requester waiting
        do_reset();
        rr_mode = 2;
        hold_cnt = 0;
        push(1, 9, 1, 0);
        push(3, 4, 1, 0);
        wait_done("hold", 400);
        check("hold.nres", 32'(nlog), 32'd2);
        check_log("hold0", 0, 1, 9, 1, 0);
        check_log("hold1", 1, 3, 4, 1, 0);

        // valid gaps
        do_reset();
        rr_mode = 0;
        en_cnt = 0;
        push(1, 7, 0, 0);
        push(1, 8, 1, 3);
        wait_done("gaps", 200);
        check_log("gaps", 0, 1, 15, 2, 0);
        check("gaps.acc_en_cycles", 32'(en_cnt), 32'd2);

        // reset in the middle of a burst
        do_reset();
        for (int i = 0; i < 4; i++) push(0, 1, i == 3, 2);
        acc_cnt = 0;
        begin
            bit seen = 0;
            for (int k = 0; k < 200; k++) begin
                @(posedge clock);
                #2;
                if (acc_cnt >= 2) begin
                    seen = 1;
                    break;
                end
            end
            check("midrst.two_beats", 32'(seen), 32'd1);
        end
        rst = 1'b1;
        clear_queues();
        req_valid = '0;
        @(posedge clock);
        #2;
        rst = 1'b0;
        check_reset_outputs("midrst");
        nlog = 0;
        for (int i = 0; i < 4; i++) push(0, 1, i == 3, 0);
        push(1, 2, 1, 0);
        wait_done("midrst", 400);
        check("midrst.nres", 32'(nlog), 32'd2);
        check_log("midrst0", 0, 0, 4, 4, 0);
        check_log("midrst1", 1, 1, 2, 1, 0);

        // randomized traffic
        do_reset();
        rnd_gaps = 1;
        rr_mode = 1;
        nb = 0;
        for (int r = 0; r < NUM_REQ; r++) begin
            exp_tot[r] = 0;
            got_tot[r] = 0;
            for (int b = 0; b < 3; b++) begin
                int len;
                len = int'($urandom_range(1, 8));
                for (int j = 0; j < len; j++) begin
                    int d;
                    d = int'($urandom_range(0, 255));
                    exp_tot[r] += d;
                    push(r, d, j == len - 1, int'($urandom_range(0, 2)));
                end
                nb++;
            end
        end
        for (int j = 0; j < 260; j++) begin
            int d;
            d = int'($urandom_range(0, 255));
            exp_tot[3] += d;
            push(3, d, j == 259, 0);
        end
        nb += 2;
        wait_done("random", 20000);
        check("random.nres", 32'(nlog), 32'(nb));
        for (int i = 0; i < nlog && i < 64; i++) got_tot[log_id[i]] += log_sum[i];
        for (int r = 0; r < NUM_REQ; r++) check("random.req_total", 32'(got_tot[r]), 32'(exp_tot[r]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
